// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial accumulator ALU: opcodes, FSM states
// and the legal range for the accumulator width.
package alu_pkg;

    localparam int DW_MIN  = 4;
    localparam int DW_MAX  = 32;
    localparam int DW_STEP = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_CLC = 4'd4,
        OP_STC = 4'd5,
        OP_CMA = 4'd6,
        OP_CMC = 4'd7,
        OP_RAL = 4'd8,
        OP_RAR = 4'd9,
        OP_IAC = 4'd10,
        OP_DAC = 4'd11,
        OP_TCC = 4'd12,
        OP_DAA = 4'd13,
        OP_KBP = 4'd14,
        OP_ILL = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DAA  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic bit dw_is_legal(input int dw);
        return (dw >= DW_MIN) && (dw <= DW_MAX) && ((dw % DW_STEP) == 0);
    endfunction

endpackage

// File: rtl/alu_kbp_enc.sv
// Keyboard-process encoder: one-hot position to (index+1), zero to zero,
// anything else to all ones.
module alu_kbp_enc #(
    parameter int DW = 4
) (
    input  logic [DW-1:0] acc,
    output logic [DW-1:0] kbp
);

    logic [5:0] ones;
    logic [5:0] pos;

    always_comb begin
        ones = '0;
        pos  = '0;
        for (int k = 0; k < DW; k++) begin
            if (acc[k]) begin
                ones = ones + 6'd1;
                pos  = 6'(k + 1);
            end
        end
        if (ones == 6'd0) begin
            kbp = '0;
        end else if (ones == 6'd1) begin
            kbp = DW'(pos);
        end else begin
            kbp = '1;
        end
    end

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator ALU with valid/ready handshakes; single-cycle ops plus a
// nibble-serial decimal adjust (one nibble per clock).
module alu_acc_seq
    import alu_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [3:0]    op_code,
    input  logic [DW-1:0] op_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] acc_out,
    output logic          cy_out,
    output logic          err_illegal
);

    localparam int NIB = DW / 4;

    generate
        if (!dw_is_legal(DW)) begin : g_dw_illegal
            $error("alu_acc_seq: DW must be a multiple of 4 in 4..32");
        end
    endgenerate

    state_e        state, state_nxt;
    logic [DW-1:0] acc;
    logic          cy;
    logic          err_q;
    logic [2:0]    nib_idx;
    logic          daa_ci;
    logic          accept;
    logic          daa_last;

    logic [DW-1:0] kbp_val;
    logic [DW-1:0] alu_acc;
    logic          alu_cy;
    logic          alu_err;
    logic [DW:0]   sum;

    logic [DW-1:0] daa_shr;
    logic [3:0]    daa_nib;
    logic [4:0]    daa_sum;
    logic [DW-1:0] daa_acc;
    logic [4:0]    daa_sh;

    assign op_ready    = rst_n && (state == S_IDLE);
    assign accept      = op_valid && op_ready;
    assign daa_last    = (nib_idx == 3'(NIB - 1));
    assign res_valid   = (state == S_RESP);
    assign acc_out     = acc;
    assign cy_out      = cy;
    assign err_illegal = err_q;

    alu_kbp_enc #(.DW(DW)) u_kbp (
        .acc (acc),
        .kbp (kbp_val)
    );

    // Single-cycle result of the opcode presented at acceptance
    always_comb begin
        alu_acc = acc;
        alu_cy  = cy;
        alu_err = 1'b0;
        sum     = '0;
        case (op_e'(op_code))
            OP_LDA: alu_acc = op_data;
            OP_ADD: begin
                sum = {1'b0, acc} + {1'b0, op_data} + {{DW{1'b0}}, cy};
                {alu_cy, alu_acc} = sum;
            end
            OP_SUB: begin
                sum = {1'b0, acc} + {1'b0, ~op_data} + {{DW{1'b0}}, cy};
                {alu_cy, alu_acc} = sum;
            end
            OP_CLC: alu_cy = 1'b0;
            OP_STC: alu_cy = 1'b1;
            OP_CMA: alu_acc = ~acc;
            OP_CMC: alu_cy = ~cy;
            OP_RAL: {alu_cy, alu_acc} = {acc, cy};
            OP_RAR: {alu_acc, alu_cy} = {cy, acc};
            OP_IAC: begin
                sum = {1'b0, acc} + {{DW{1'b0}}, 1'b1};
                {alu_cy, alu_acc} = sum;
            end
            OP_DAC: begin
                alu_acc = acc - DW'(1);
                alu_cy  = |acc;
            end
            OP_TCC: begin
                alu_acc = {{(DW-1){1'b0}}, cy};
                alu_cy  = 1'b0;
            end
            OP_KBP: alu_acc = kbp_val;
            OP_ILL: alu_err = 1'b1;
            default: ;
        endcase
    end

    // One decimal-adjust step on the nibble selected by nib_idx
    always_comb begin
        daa_sh  = {nib_idx, 2'b00};
        daa_shr = acc >> daa_sh;
        daa_nib = daa_shr[3:0];
        daa_sum = {1'b0, daa_nib}
                + (((daa_nib > 4'd9) || ((nib_idx == 3'd0) && cy)) ? 5'd6 : 5'd0)
                + {4'b0000, daa_ci};
        daa_acc = (acc & ~(DW'(4'hF) << daa_sh)) | (DW'(daa_sum[3:0]) << daa_sh);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = (op_e'(op_code) == OP_DAA) ? S_DAA : S_RESP;
            S_DAA:  if (daa_last) state_nxt = S_RESP;
            S_RESP: if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            cy      <= 1'b0;
            err_q   <= 1'b0;
            nib_idx <= '0;
            daa_ci  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc     <= alu_acc;
                        cy      <= alu_cy;
                        err_q   <= alu_err;
                        nib_idx <= '0;
                        daa_ci  <= 1'b0;
                    end
                end
                S_DAA: begin
                    acc     <= daa_acc;
                    daa_ci  <= daa_sum[4];
                    nib_idx <= nib_idx + 3'd1;
                    // cy keeps its original value until the last nibble, which step 0 relies on
                    if (daa_last) begin
                        cy      <= cy | daa_sum[4];
                        nib_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Bench for alu_acc_seq at DW=4, 8 and 16 against an arithmetic reference model.
module tb_alu_acc_seq;

    logic        clk;
    logic        rst_n     [3];
    logic        op_valid  [3];
    logic        op_ready  [3];
    logic [3:0]  op_code   [3];
    logic [31:0] op_data   [3];
    logic        res_valid [3];
    logic        res_ready [3];
    logic [31:0] acc_o     [3];
    logic        cy_o      [3];
    logic        err_o     [3];

    logic [3:0]  acc4;
    logic [7:0]  acc8;
    logic [15:0] acc16;

    int n_tests = 0;
    int n_fail  = 0;

    longint unsigned m_acc [3];
    bit              m_cy  [3];

    assign acc_o[0] = {28'd0, acc4};
    assign acc_o[1] = {24'd0, acc8};
    assign acc_o[2] = {16'd0, acc16};

    alu_acc_seq #(.DW(4)) dut4 (
        .clk(clk), .rst_n(rst_n[0]), .op_valid(op_valid[0]), .op_ready(op_ready[0]),
        .op_code(op_code[0]), .op_data(op_data[0][3:0]), .res_valid(res_valid[0]),
        .res_ready(res_ready[0]), .acc_out(acc4), .cy_out(cy_o[0]), .err_illegal(err_o[0]));

    alu_acc_seq #(.DW(8)) dut8 (
        .clk(clk), .rst_n(rst_n[1]), .op_valid(op_valid[1]), .op_ready(op_ready[1]),
        .op_code(op_code[1]), .op_data(op_data[1][7:0]), .res_valid(res_valid[1]),
        .res_ready(res_ready[1]), .acc_out(acc8), .cy_out(cy_o[1]), .err_illegal(err_o[1]));

    alu_acc_seq #(.DW(16)) dut16 (
        .clk(clk), .rst_n(rst_n[2]), .op_valid(op_valid[2]), .op_ready(op_ready[2]),
        .op_code(op_code[2]), .op_data(op_data[2][15:0]), .res_valid(res_valid[2]),
        .res_ready(res_ready[2]), .acc_out(acc16), .cy_out(cy_o[2]), .err_illegal(err_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int dw_of(input int u);
        return (u == 0) ? 4 : ((u == 1) ? 8 : 16);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour computed directly from the opcode definitions
    function automatic void ref_op(input int dw, input int op, input logic [31:0] d_in,
                                   inout longint unsigned a, inout bit cy, output bit err);
        longint unsigned m, d, s, nib, t, ci;
        int pc, pos;
        bit nc;
        m   = (64'd1 << dw) - 1;
        d   = longint'(d_in) & m;
        err = 1'b0;
        case (op)
            1:  a = d;
            2:  begin s = a + d + cy;          a = s & m; cy = ((s >> dw) & 1) != 0; end
            3:  begin s = a + (~d & m) + cy;   a = s & m; cy = ((s >> dw) & 1) != 0; end
            4:  cy = 1'b0;
            5:  cy = 1'b1;
            6:  a = ~a & m;
            7:  cy = !cy;
            8:  begin nc = ((a >> (dw - 1)) & 1) != 0; a = ((a << 1) | cy) & m; cy = nc; end
            9:  begin nc = (a & 1) != 0; a = (a >> 1) | (longint'(cy) << (dw - 1)); cy = nc; end
            10: begin s = a + 1; a = s & m; cy = ((s >> dw) & 1) != 0; end
            11: begin cy = (a != 0); a = (a - 1) & m; end
            12: begin a = cy; cy = 1'b0; end
            13: begin
                ci = 0;
                for (int i = 0; i < dw / 4; i++) begin
                    nib = (a >> (4 * i)) & 15;
                    t   = nib + (((nib > 9) || (i == 0 && cy)) ? 6 : 0) + ci;
                    a   = (a & ~(64'd15 << (4 * i))) | ((t & 15) << (4 * i));
                    ci  = t >> 4;
                end
                cy = cy | (ci != 0);
            end
            14: begin
                pc = 0; pos = 0;
                for (int k = 0; k < dw; k++) if (((a >> k) & 1) != 0) begin pc++; pos = k + 1; end
                a = (pc == 0) ? 0 : ((pc == 1) ? longint'(pos) : m);
            end
            15: err = 1'b1;
            default: ;
        endcase
    endfunction

    task automatic do_op(input int u, input int op, input logic [31:0] d, input int hold);
        longint unsigned ea;
        bit ec, ee;
        int n, lat, exp_lat;
        ea = m_acc[u];
        ec = m_cy[u];
        ref_op(dw_of(u), op, d, ea, ec, ee);
        exp_lat = (op == 13) ? dw_of(u) / 4 + 1 : 1;
        n = 0;
        while (!op_ready[u] && n < 50) begin @(negedge clk); n++; end
        chk("op_ready_idle", {31'd0, op_ready[u]}, 32'd1);
        op_valid[u]  = 1'b1;
        op_code[u]   = 4'(op);
        op_data[u]   = d;
        res_ready[u] = 1'b0;
        @(negedge clk);
        op_valid[u] = 1'b0;
        op_code[u]  = 4'($urandom);
        op_data[u]  = $urandom;
        lat = 1;
        while (!res_valid[u] && lat < 40) begin
            chk("op_ready_busy", {31'd0, op_ready[u]}, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("acc", acc_o[u], 32'(ea));
        chk("cy", {31'd0, cy_o[u]}, {31'd0, ec});
        chk("err", {31'd0, err_o[u]}, {31'd0, ee});
        m_acc[u] = ea;
        m_cy[u]  = ec;
        for (int i = 0; i < hold; i++) begin
            op_valid[u] = 1'($urandom);
            op_code[u]  = 4'($urandom);
            op_data[u]  = $urandom;
            @(negedge clk);
            chk("hold_valid", {31'd0, res_valid[u]}, 32'd1);
            chk("hold_ready", {31'd0, op_ready[u]}, 32'd0);
            chk("hold_acc", acc_o[u], 32'(ea));
            chk("hold_cy", {31'd0, cy_o[u]}, {31'd0, ec});
            chk("hold_err", {31'd0, err_o[u]}, {31'd0, ee});
        end
        op_valid[u]  = 1'b0;
        res_ready[u] = 1'b1;
        @(negedge clk);
        res_ready[u] = 1'b0;
        chk("resp_done", {31'd0, res_valid[u]}, 32'd0);
        chk("post_acc", acc_o[u], 32'(ea));
    endtask

    task automatic reset_all();
        for (int u = 0; u < 3; u++) begin
            rst_n[u] = 1'b0; op_valid[u] = 1'b0; res_ready[u] = 1'b0;
            op_code[u] = 4'd0; op_data[u] = 32'd0;
            m_acc[u] = 0; m_cy[u] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("rst_acc", acc_o[u], 32'd0);
            chk("rst_cy", {31'd0, cy_o[u]}, 32'd0);
            chk("rst_res_valid", {31'd0, res_valid[u]}, 32'd0);
            chk("rst_err", {31'd0, err_o[u]}, 32'd0);
            chk("rst_op_ready", {31'd0, op_ready[u]}, 32'd0);
            rst_n[u] = 1'b1;
        end
        @(negedge clk);
        for (int u = 0; u < 3; u++) chk("rel_op_ready", {31'd0, op_ready[u]}, 32'd1);
    endtask

    initial begin
        reset_all();

        // ADD with carry-in at DW=4
        do_op(0, 1, 32'h9, 0);
        do_op(0, 5, 32'h0, 0);
        do_op(0, 2, 32'h8, 0);
        chk("add_acc", acc_o[0], 32'h2);
        chk("add_cy", {31'd0, cy_o[0]}, 32'd1);

        // SUB without borrow, then rotate left through carry
        do_op(0, 1, 32'h5, 0);
        do_op(0, 5, 32'h0, 0);
        do_op(0, 3, 32'h3, 0);
        chk("sub_acc", acc_o[0], 32'h2);
        chk("sub_cy", {31'd0, cy_o[0]}, 32'd1);
        do_op(0, 1, 32'h9, 0);
        do_op(0, 4, 32'h0, 0);
        do_op(0, 8, 32'h0, 0);
        chk("ral_acc", acc_o[0], 32'h2);
        chk("ral_cy", {31'd0, cy_o[0]}, 32'd1);

        // DAA at DW=8
        do_op(1, 1, 32'h1B, 0);
        do_op(1, 4, 32'h0, 0);
        do_op(1, 13, 32'h0, 0);
        chk("daa_acc", acc_o[1], 32'h21);
        chk("daa_cy", {31'd0, cy_o[1]}, 32'd0);

        // KBP encodings
        do_op(0, 1, 32'h4, 0);
        do_op(0, 14, 32'h0, 0);
        chk("kbp_one", acc_o[0], 32'h3);
        do_op(0, 1, 32'h6, 0);
        do_op(0, 14, 32'h0, 0);
        chk("kbp_multi", acc_o[0], 32'hF);
        do_op(1, 1, 32'h80, 0);
        do_op(1, 14, 32'h0, 0);
        chk("kbp_msb", acc_o[1], 32'h8);
        do_op(1, 1, 32'h0, 0);
        do_op(1, 14, 32'h0, 0);
        chk("kbp_zero", acc_o[1], 32'h0);

        // Illegal opcode held in RESP for 5 cycles
        do_op(0, 1, 32'hA, 0);
        do_op(0, 15, 32'h3, 5);
        chk("ill_acc", acc_o[0], 32'hA);

        // Reset during the second DAA cycle at DW=16
        do_op(2, 1, 32'h123B, 0);
        do_op(2, 4, 32'h0, 0);
        op_valid[2] = 1'b1;
        op_code[2]  = 4'd13;
        @(negedge clk);
        op_valid[2] = 1'b0;
        chk("daa16_busy", {31'd0, op_ready[2]}, 32'd0);
        @(negedge clk);
        chk("daa16_partial", acc_o[2], 32'h1231);
        rst_n[2] = 1'b0;
        @(negedge clk);
        chk("midrst_acc", acc_o[2], 32'd0);
        chk("midrst_cy", {31'd0, cy_o[2]}, 32'd0);
        chk("midrst_valid", {31'd0, res_valid[2]}, 32'd0);
        chk("midrst_ready", {31'd0, op_ready[2]}, 32'd0);
        rst_n[2] = 1'b1;
        m_acc[2] = 0;
        m_cy[2]  = 1'b0;
        @(negedge clk);
        chk("midrst_rel_ready", {31'd0, op_ready[2]}, 32'd1);
        chk("midrst_rel_valid", {31'd0, res_valid[2]}, 32'd0);

        // Randomized operations on every width
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 120; i++) begin
                do_op(u, int'($urandom_range(0, 15)), $urandom,
                      (($urandom % 8) == 0) ? 2 : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
